// File: rtl/micro_seq.sv
// micro_seq: microprogram sequencer. Owns the micro-PC, fetches words from a
// one-cycle synchronous microcode ROM, issues them to the decoder, resolves
// two-word conditional branches against the ALU flags and stops on a halt word.
module micro_seq #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stall,
    output logic [AW-1:0] rom_addr,
    input  logic [8:0]    rom_data,
    input  logic          flag_z,
    input  logic          flag_c,
    input  logic          flag_n,
    output logic [8:0]    ms_m,
    output logic          ms_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        TARGET,
        TLOAD
    } state_t;

    localparam logic [AW-1:0] ONE = AW'(1);
    localparam logic [AW-1:0] TWO = AW'(2);

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] upc_q;
    logic [AW-1:0] upc_d;
    logic [AW-1:0] addr_d;
    logic [8:0]    ms_m_d;
    logic          valid_d;
    logic          done_d;
    logic          taken;
    logic [2:0]    opcode;
    logic [2:0]    cond;

    assign opcode = rom_data[8:6];
    assign cond   = rom_data[2:0];
    assign busy   = (state_q != IDLE);

    // Evaluate the branch condition in field B against the live ALU flags
    always_comb begin
        taken = 1'b0;
        case (cond)
            3'b001:  taken = 1'b1;
            3'b010:  taken = flag_z;
            3'b011:  taken = ~flag_z;
            3'b100:  taken = flag_c;
            3'b101:  taken = ~flag_c;
            3'b110:  taken = flag_n;
            default: taken = 1'b0;
        endcase
    end

    // Next-state, next-PC and next-output logic; outputs idle to NOP by default
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        addr_d  = rom_addr;
        ms_m_d  = 9'h000;
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    upc_d   = '0;
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                if (!stall) begin
                    if (opcode != 3'b111) begin
                        ms_m_d  = rom_data;
                        valid_d = 1'b1;
                        upc_d   = upc_q + ONE;
                        addr_d  = upc_q + ONE;
                        state_d = FETCH;
                    end else if (cond == 3'b111) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (taken) begin
                        ms_m_d  = rom_data;
                        valid_d = 1'b1;
                        addr_d  = upc_q + ONE;
                        state_d = TARGET;
                    end else begin
                        ms_m_d  = rom_data;
                        valid_d = 1'b1;
                        upc_d   = upc_q + TWO;
                        addr_d  = upc_q + TWO;
                        state_d = FETCH;
                    end
                end
            end
            TARGET: begin
                state_d = TLOAD;
            end
            TLOAD: begin
                upc_d   = rom_data[AW-1:0];
                addr_d  = rom_data[AW-1:0];
                state_d = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, micro-PC and registered outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            upc_q    <= '0;
            rom_addr <= '0;
            ms_m     <= 9'h000;
            ms_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            upc_q    <= upc_d;
            rom_addr <= addr_d;
            ms_m     <= ms_m_d;
            ms_valid <= valid_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_micro_seq.sv
// tb_micro_seq: bench for micro_seq. A behavioural interpreter walks the
// microprogram instruction by instruction, charging each word its cycle cost,
// and produces the expected per-cycle output trace that the DUT must follow.
module tb_micro_seq;

    localparam int AW   = 6;
    localparam int MAXC = 256;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stall;
    logic [AW-1:0] rom_addr;
    logic [8:0]    rom_data;
    logic          flag_z;
    logic          flag_c;
    logic          flag_n;
    logic [8:0]    ms_m;
    logic          ms_valid;
    logic          busy;
    logic          done;

    logic [8:0] rom [64];
    bit         stall_pat [MAXC];
    bit         start_pat [MAXC];
    bit         fz_pat [MAXC];
    bit         fc_pat [MAXC];
    bit         fn_pat [MAXC];

    bit         exp_valid [MAXC];
    logic [8:0] exp_m [MAXC];
    bit         exp_done [MAXC];
    bit         exp_busy [MAXC];
    bit         exp_chk [MAXC];
    int         exp_addr [MAXC];

    logic       obs_valid [MAXC];
    logic [8:0] obs_m [MAXC];
    logic       obs_done [MAXC];
    logic       obs_busy [MAXC];
    logic [5:0] obs_addr [MAXC];

    int halt_edge;
    int pass_cnt = 0;
    int total_cnt = 0;

    micro_seq #(.AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stall    (stall),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .flag_z   (flag_z),
        .flag_c   (flag_c),
        .flag_n   (flag_n),
        .ms_m     (ms_m),
        .ms_valid (ms_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle synchronous microcode ROM
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s cycle %0d: got %0h, expected %0h", name, k, act, exp);
    endtask

    function automatic bit cond_true(input logic [2:0] c, input bit z, input bit cy, input bit n);
        case (c)
            3'd1:    return 1'b1;
            3'd2:    return z;
            3'd3:    return !z;
            3'd4:    return cy;
            3'd5:    return !cy;
            3'd6:    return n;
            default: return 1'b0;
        endcase
    endfunction

    // Interpret the microprogram: plain/not-taken words cost 2 cycles plus stalls, taken branches 4
    task automatic build_model(input int n, input int rst_at);
        int pc, t, j;
        logic [8:0] w;
        bit fin;
        for (int k = 0; k <= n; k++) begin
            exp_valid[k] = 0; exp_m[k] = 9'h000; exp_done[k] = 0;
            exp_busy[k] = 1; exp_chk[k] = 0; exp_addr[k] = 0;
        end
        halt_edge = n + 1;
        pc = 0; t = 0; fin = 0;
        exp_chk[0] = 1;
        while (!fin) begin
            j = t + 2;
            while (j <= n && stall_pat[j]) j++;
            if (j > n) fin = 1;
            else begin
                w = rom[pc];
                if (w[8:6] != 3'b111) begin
                    exp_valid[j] = 1; exp_m[j] = w;
                    pc = (pc + 1) % 64; t = j;
                end else if (w[2:0] == 3'b111) begin
                    exp_done[j] = 1; halt_edge = j; fin = 1;
                end else if (cond_true(w[2:0], fz_pat[j], fc_pat[j], fn_pat[j])) begin
                    exp_valid[j] = 1; exp_m[j] = w;
                    exp_chk[j] = 1; exp_addr[j] = (pc + 1) % 64;
                    pc = int'(rom[(pc + 1) % 64] & 9'h03F); t = j + 2;
                end else begin
                    exp_valid[j] = 1; exp_m[j] = w;
                    pc = (pc + 2) % 64; t = j;
                end
                if (!fin && t <= n) begin
                    exp_chk[t] = 1; exp_addr[t] = pc;
                end
            end
        end
        for (int k = halt_edge; k <= n; k++) exp_busy[k] = 0;
        for (int k = rst_at; k <= n; k++) begin
            exp_valid[k] = 0; exp_m[k] = 9'h000; exp_done[k] = 0;
            exp_busy[k] = 0; exp_chk[k] = 1; exp_addr[k] = 0;
        end
    endtask

    task automatic applyStimulus(input int k, input int rst_at);
        start  = (k == 0) ? 1'b1 : start_pat[k];
        stall  = stall_pat[k];
        flag_z = fz_pat[k];
        flag_c = fc_pat[k];
        flag_n = fn_pat[k];
        rst    = (k == rst_at);
    endtask

    task automatic checkOutput(input int k);
        obs_valid[k] = ms_valid; obs_m[k] = ms_m; obs_done[k] = done;
        obs_busy[k] = busy; obs_addr[k] = rom_addr;
        check("ms_valid", k, 16'(ms_valid), 16'(exp_valid[k]));
        check("ms_m", k, 16'(ms_m), 16'(exp_m[k]));
        check("done", k, 16'(done), 16'(exp_done[k]));
        check("busy", k, 16'(busy), 16'(exp_busy[k]));
        if (exp_chk[k]) check("rom_addr", k, 16'(rom_addr), 16'(exp_addr[k]));
    endtask

    task automatic clear_patterns();
        for (int i = 0; i < 64; i++) rom[i] = 9'h1C7;
        for (int k = 0; k < MAXC; k++) begin
            stall_pat[k] = 0; start_pat[k] = 0;
            fz_pat[k] = 0; fc_pat[k] = 0; fn_pat[k] = 0;
        end
    endtask

    task automatic run_program(input int n, input int rst_at, input bit noise);
        build_model(n, rst_at);
        if (noise)
            for (int k = 1; k <= n; k++)
                start_pat[k] = (k <= halt_edge && k < rst_at) ? ($urandom_range(0, 3) == 0) : 1'b0;
        @(negedge clk);
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        check("reset_valid", -1, 16'(ms_valid), 16'h0);
        check("reset_m", -1, 16'(ms_m), 16'h0);
        check("reset_done", -1, 16'(done), 16'h0);
        check("reset_busy", -1, 16'(busy), 16'h0);
        check("reset_addr", -1, 16'(rom_addr), 16'h0);
        for (int k = 0; k <= n; k++) begin
            @(negedge clk);
            applyStimulus(k, rst_at);
            @(posedge clk); #1;
            checkOutput(k);
        end
        @(negedge clk);
        start = 1'b0; stall = 1'b0; rst = 1'b0;
    endtask

    initial begin
        int cnt;
        logic [8:0] w;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        flag_z = 1'b0; flag_c = 1'b0; flag_n = 1'b0;

        // Straight line
        clear_patterns();
        rom[0] = 9'h050; rom[1] = 9'h0CB; rom[2] = 9'h1C7;
        run_program(8, 999, 0);
        check("sl_valid_e2", 2, 16'(obs_valid[2]), 16'h1);
        check("sl_m_e2", 2, 16'(obs_m[2]), 16'h050);
        check("sl_m_e3", 3, 16'(obs_m[3]), 16'h000);
        check("sl_m_e4", 4, 16'(obs_m[4]), 16'h0CB);
        check("sl_done_e6", 6, 16'(obs_done[6]), 16'h1);
        check("sl_valid_e6", 6, 16'(obs_valid[6]), 16'h0);
        check("sl_busy_e6", 6, 16'(obs_busy[6]), 16'h0);

        // Taken branch
        clear_patterns();
        rom[0] = 9'h1C1; rom[1] = 9'h005; rom[5] = 9'h1C7;
        run_program(8, 999, 0);
        check("tb_m_e2", 2, 16'(obs_m[2]), 16'h1C1);
        check("tb_addr_e2", 2, 16'(obs_addr[2]), 16'd1);
        check("tb_addr_e4", 4, 16'(obs_addr[4]), 16'd5);
        check("tb_valid_e4", 4, 16'(obs_valid[4]), 16'h0);
        check("tb_done_e6", 6, 16'(obs_done[6]), 16'h1);

        // Conditional, Z clear then Z set
        clear_patterns();
        rom[0] = 9'h1C2; rom[1] = 9'h004; rom[2] = 9'h050; rom[3] = 9'h1C7; rom[4] = 9'h1C7;
        run_program(8, 999, 0);
        check("cz0_m_e4", 4, 16'(obs_m[4]), 16'h050);
        check("cz0_done_e6", 6, 16'(obs_done[6]), 16'h1);
        for (int k = 0; k < MAXC; k++) fz_pat[k] = 1;
        run_program(8, 999, 0);
        check("cz1_valid_e4", 4, 16'(obs_valid[4]), 16'h0);
        check("cz1_addr_e4", 4, 16'(obs_addr[4]), 16'd4);
        check("cz1_done_e6", 6, 16'(obs_done[6]), 16'h1);

        // Stall in first ISSUE with a stray start
        clear_patterns();
        rom[0] = 9'h050; rom[1] = 9'h0CB; rom[2] = 9'h1C7;
        stall_pat[2] = 1; stall_pat[3] = 1; stall_pat[4] = 1; start_pat[3] = 1;
        run_program(11, 999, 0);
        cnt = 0;
        for (int k = 0; k <= 11; k++) if (obs_valid[k] === 1'b1 && obs_m[k] === 9'h050) cnt++;
        check("st_issue_once", 5, 16'(cnt), 16'd1);
        check("st_valid_e4", 4, 16'(obs_valid[4]), 16'h0);
        check("st_m_e5", 5, 16'(obs_m[5]), 16'h050);
        check("st_done_e9", 9, 16'(obs_done[9]), 16'h1);

        // Wrap at the last address, then reset during FETCH
        clear_patterns();
        rom[0] = 9'h1C1; rom[1] = 9'h03F; rom[63] = 9'h050;
        run_program(8, 7, 0);
        check("wr_addr_e4", 4, 16'(obs_addr[4]), 16'd63);
        check("wr_m_e6", 6, 16'(obs_m[6]), 16'h050);
        check("wr_addr_e6", 6, 16'(obs_addr[6]), 16'd0);
        check("wr_rst_busy", 7, 16'(obs_busy[7]), 16'h0);
        check("wr_rst_addr", 7, 16'(obs_addr[7]), 16'd0);

        // Not-taken branch at 62 moves to 0
        clear_patterns();
        rom[0] = 9'h1C1; rom[1] = 9'h03E; rom[62] = 9'h1C0;
        run_program(7, 999, 0);
        check("nt_m_e6", 6, 16'(obs_m[6]), 16'h1C0);
        check("nt_addr_e6", 6, 16'(obs_addr[6]), 16'd0);

        // Randomised programs, stalls, flags, stray starts and resets
        for (int r = 0; r < 24; r++) begin
            clear_patterns();
            for (int i = 0; i < 64; i++) begin
                w = 9'($urandom);
                cnt = int'($urandom_range(0, 7));
                if (cnt == 0) w = {3'b111, w[5:3], 3'b111};
                else if (cnt <= 2) w[8:6] = 3'b111;
                rom[i] = w;
            end
            for (int k = 0; k < MAXC; k++) begin
                stall_pat[k] = ($urandom_range(0, 3) == 0);
                fz_pat[k] = 1'($urandom); fc_pat[k] = 1'($urandom); fn_pat[k] = 1'($urandom);
            end
            run_program(120, ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 120)) : 999, 1);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
